// File: rtl/dict_compressor_if.sv
// Handshake bundle for dict_compressor: the serial bit input and the index output.
// Signal prefixes are from the compressor's point of view.
interface dict_compressor_if #(
  parameter int CHUNK_SIZE = 4,
  parameter int INDEX_BITS = 3
);
  logic                  i_serial_in;
  logic                  i_shift_enable;
  logic                  o_shift_ready;
  logic [CHUNK_SIZE-1:0] o_assembled_chunk;
  logic [INDEX_BITS-1:0] o_compressed_index;
  logic                  o_exact_hit;
  logic                  o_index_valid;
  logic                  i_index_ready;

  modport master (
    output i_serial_in, i_shift_enable, i_index_ready,
    input  o_shift_ready, o_assembled_chunk, o_compressed_index, o_exact_hit, o_index_valid
  );

  modport slave (
    input  i_serial_in, i_shift_enable, i_index_ready,
    output o_shift_ready, o_assembled_chunk, o_compressed_index, o_exact_hit, o_index_valid
  );
endinterface

// File: rtl/dict_compressor.sv
// Serial-in dictionary compressor: assembles MSB-first chunks and emits the nearest codebook index.
// Optional DICT_MISS_COUNT_EN adds a saturating count of non-exact transfers on o_miss_count.
module dict_compressor #(
  parameter int CHUNK_SIZE    = 4,
  parameter int CODEBOOK_SIZE = 8,
  parameter logic [CHUNK_SIZE*CODEBOOK_SIZE-1:0] CODEBOOK = 32'h7C8F_B920
) (
  input  logic              clk,
  input  logic              rst_n,
  dict_compressor_if.slave  bus
`ifdef DICT_MISS_COUNT_EN
  ,
  output logic [15:0]       o_miss_count
`endif
);

  localparam int INDEX_BITS = $clog2(CODEBOOK_SIZE);
  localparam int DIST_W     = $clog2(CHUNK_SIZE + 1);
  localparam int CNT_W      = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNK_SIZE - 1);

  logic [CHUNK_SIZE-1:0] r_shift;
  logic [CNT_W-1:0]      r_bitCount;
  logic                  r_chunkFull;
  logic [CHUNK_SIZE-1:0] r_chunk;
  logic [INDEX_BITS-1:0] r_index;
  logic                  r_exact;
  logic                  r_valid;

  logic                  w_slotFree;
  logic                  w_transfer;
  logic                  w_shiftReady;
  logic                  w_accept;
  logic [INDEX_BITS-1:0] w_bestIdx;
  logic [DIST_W-1:0]     w_bestDist;
  logic                  w_exact;

  function automatic logic [DIST_W-1:0] hamming(input logic [CHUNK_SIZE-1:0] a,
                                                input logic [CHUNK_SIZE-1:0] b);
    logic [CHUNK_SIZE-1:0] diff;
    logic [DIST_W-1:0]     cnt;
    diff = a ^ b;
    cnt  = '0;
    for (int k = 0; k < CHUNK_SIZE; k++) begin
      cnt = cnt + DIST_W'(diff[k]);
    end
    return cnt;
  endfunction

  assign w_slotFree   = !r_valid || bus.i_index_ready;
  assign w_transfer   = r_chunkFull && w_slotFree;
  assign w_shiftReady = !r_chunkFull || w_slotFree;
  assign w_accept     = bus.i_shift_enable && w_shiftReady;

  // Strict-less scan from entry 0 keeps the lowest index on distance ties.
  always_comb begin
    logic [DIST_W-1:0] w_dist;
    w_bestIdx  = '0;
    w_bestDist = hamming(r_shift, CODEBOOK[0 +: CHUNK_SIZE]);
    w_dist     = '0;
    for (int i = 1; i < CODEBOOK_SIZE; i++) begin
      w_dist = hamming(r_shift, CODEBOOK[i*CHUNK_SIZE +: CHUNK_SIZE]);
      if (w_dist < w_bestDist) begin
        w_bestDist = w_dist;
        w_bestIdx  = INDEX_BITS'(i);
      end
    end
    w_exact = (w_bestDist == '0);
  end

  // A bit accepted on a transfer edge starts the next chunk, so chunk_full can re-set that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bitCount  <= '0;
      r_chunkFull <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= {r_shift[CHUNK_SIZE-2:0], bus.i_serial_in};
        if (r_bitCount == LAST_CNT) begin
          r_bitCount  <= '0;
          r_chunkFull <= 1'b1;
        end else begin
          r_bitCount <= r_bitCount + CNT_W'(1);
          if (w_transfer) r_chunkFull <= 1'b0;
        end
      end else if (w_transfer) begin
        r_chunkFull <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk <= '0;
      r_index <= '0;
      r_exact <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_transfer) begin
      r_chunk <= r_shift;
      r_index <= w_bestIdx;
      r_exact <= w_exact;
      r_valid <= 1'b1;
    end else if (r_valid && bus.i_index_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DICT_MISS_COUNT_EN
  logic [15:0] r_missCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_missCount <= '0;
    end else if (w_transfer && !w_exact && (r_missCount != 16'hFFFF)) begin
      r_missCount <= r_missCount + 16'd1;
    end
  end

  assign o_miss_count = r_missCount;
`endif

  assign bus.o_shift_ready      = w_shiftReady;
  assign bus.o_assembled_chunk  = r_chunk;
  assign bus.o_compressed_index = r_index;
  assign bus.o_exact_hit        = r_exact;
  assign bus.o_index_valid      = r_valid;

endmodule

// File: tb/tb_dict_compressor.sv
// Directed bench for dict_compressor: expected results are queued as chunks are sent
// and popped by a monitor whenever an index is handed downstream.
module tb_dict_compressor;

  typedef struct {
    logic [3:0] chunk;
    logic [2:0] idx;
    logic       exact;
  } expT;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  expT  expQ[$];
  logic [31:0] cbFlat;

  dict_compressor_if #(.CHUNK_SIZE(4), .INDEX_BITS(3)) busIf ();

`ifdef DICT_MISS_COUNT_EN
  logic [15:0] missCount;
`endif

  dict_compressor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
`ifdef DICT_MISS_COUNT_EN
    ,
    .o_miss_count (missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one bit for a cycle and checks the ready flag it should see.
  task automatic applyStimulus(input logic b, input logic expReady);
    busIf.i_serial_in    = b;
    busIf.i_shift_enable = 1'b1;
    @(negedge clk);
    checkOutput("shift_ready", {31'd0, busIf.o_shift_ready}, {31'd0, expReady});
    @(posedge clk);
    #1;
    busIf.i_shift_enable = 1'b0;
  endtask

  task automatic sendChunk(input logic [3:0] c, input logic [2:0] idx, input logic exact);
    expT e;
    for (int k = 3; k >= 0; k--) begin
      applyStimulus(c[k], 1'b1);
    end
    e.chunk = c;
    e.idx   = idx;
    e.exact = exact;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor; the decode check models the downstream decompressor's table lookup.
  always @(negedge clk) begin
    expT  e;
    logic [3:0] decoded;
    if (rst_n && busIf.o_index_valid && busIf.i_index_ready) begin
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $error("[TB] FAIL unexpected_index observed=%0d expected=none", busIf.o_compressed_index);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("compressed_index", {29'd0, busIf.o_compressed_index}, {29'd0, e.idx});
        checkOutput("exact_hit", {31'd0, busIf.o_exact_hit}, {31'd0, e.exact});
        checkOutput("assembled_chunk", {28'd0, busIf.o_assembled_chunk}, {28'd0, e.chunk});
        if (e.exact) begin
          decoded = cbFlat[busIf.o_compressed_index*4 +: 4];
          checkOutput("loopback_decode", {28'd0, decoded}, {28'd0, e.chunk});
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cbFlat   = 32'h7C8F_B920;
    rst_n    = 1'b0;
    busIf.i_serial_in    = 1'b0;
    busIf.i_shift_enable = 1'b0;
    busIf.i_index_ready  = 1'b1;

    idleCycles(2);
    checkOutput("reset_valid", {31'd0, busIf.o_index_valid}, 32'd0);
    checkOutput("reset_index", {29'd0, busIf.o_compressed_index}, 32'd0);
    checkOutput("reset_exact", {31'd0, busIf.o_exact_hit}, 32'd0);
    checkOutput("reset_chunk", {28'd0, busIf.o_assembled_chunk}, 32'd0);
    checkOutput("reset_shift_ready", {31'd0, busIf.o_shift_ready}, 32'd1);
`ifdef DICT_MISS_COUNT_EN
    checkOutput("reset_miss_count", {16'd0, missCount}, 32'd0);
`endif
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] exact match 1001 and output latency");
    sendChunk(4'b1001, 3'd2, 1'b1);
    @(negedge clk);
    checkOutput("latency_not_yet_valid", {31'd0, busIf.o_index_valid}, 32'd0);
    @(negedge clk);
    checkOutput("latency_valid", {31'd0, busIf.o_index_valid}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] tie 0100 resolves to lowest index");
    sendChunk(4'b0100, 3'd0, 1'b0);
    idleCycles(2);
`ifdef DICT_MISS_COUNT_EN
    checkOutput("miss_count_after_tie", {16'd0, missCount}, 32'd1);
`endif

    $display("[TB] stall with index_ready low");
    busIf.i_index_ready = 1'b0;
    sendChunk(4'b1011, 3'd3, 1'b1);
    sendChunk(4'b0111, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("stall_held_index", {29'd0, busIf.o_compressed_index}, 32'd3);
      checkOutput("stall_held_valid", {31'd0, busIf.o_index_valid}, 32'd1);
    end
    busIf.i_index_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_shift_ready", {31'd0, busIf.o_shift_ready}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_drained", {31'd0, busIf.o_index_valid}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] continuous stream 1111 1000 1100");
    sendChunk(4'b1111, 3'd4, 1'b1);
    sendChunk(4'b1000, 3'd5, 1'b1);
    sendChunk(4'b1100, 3'd6, 1'b1);
    idleCycles(3);

    $display("[TB] reset mid-chunk discards partial bits");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_valid", {31'd0, busIf.o_index_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sendChunk(4'b0010, 3'd1, 1'b1);
    idleCycles(3);

    $display("[TB] loopback over every codebook entry");
    for (int i = 0; i < 8; i++) begin
      logic [3:0] entry;
      entry = cbFlat[i*4 +: 4];
      sendChunk(entry, 3'(i), 1'b1);
    end
    idleCycles(4);

    checkOutput("scoreboard_empty", expQ.size(), 32'd0);
`ifdef DICT_MISS_COUNT_EN
    checkOutput("miss_count_final", {16'd0, missCount}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
